// File: rtl/rom_arb_pkg.sv
// Shared types and constants for the two-port program-ROM arbiter.
package rom_arb_pkg;

  localparam int DEF_ADDR_WIDTH = 15;
  localparam int DEF_DATA_WIDTH = 8;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    ACK  = 2'd2
  } arb_state_e;

endpackage : rom_arb_pkg

// File: rtl/rr_pick2.sv
// Two-way request picker. Round-robin by default; fixed priority to port A
// when ROM_ARB_FIXED_PRIO_EN is defined. Output is only meaningful when a request is present.
module rr_pick2
  import rom_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant
);

`ifdef ROM_ARB_FIXED_PRIO_EN
  logic unused_last_grant;

  assign unused_last_grant = last_grant;
  assign grant             = req[PORT_A] ? PORT_A : PORT_B;
`else
  always_comb begin
    // NOTE: every path assigns grant, so no latch can be inferred here.
    if (req == 2'b11) begin
      grant = ~last_grant;
    end else begin
      grant = req[PORT_B];
    end
  end
`endif

endmodule : rr_pick2

// File: rtl/rom_arbiter.sv
// Shares one program ROM between the CPU fetch path (A) and a secondary reader (B).
// Arbitration mode is selected by the ROM_ARB_FIXED_PRIO_EN macro inside rr_pick2.
module rom_arbiter
  import rom_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  a_req,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  output logic                  a_ack,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_req,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  output logic                  b_ack,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  rom_oe,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic                  busy,
  output logic                  grant_b
);

  arb_state_e            state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] a_rdata_q;
  logic [DATA_WIDTH-1:0] b_rdata_q;
  logic                  grant_b_q;
  logic                  last_grant_q;
  logic                  a_ack_q;
  logic                  b_ack_q;
  logic                  busy_q;
  logic                  pick;

  rr_pick2 u_pick (
    .req        ({b_req, a_req}),
    .last_grant (last_grant_q),
    .grant      (pick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      a_rdata_q    <= '0;
      b_rdata_q    <= '0;
      grant_b_q    <= PORT_A;
      last_grant_q <= PORT_B;
      a_ack_q      <= 1'b0;
      b_ack_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      case (state_q)
        IDLE: begin
          if (a_req || b_req) begin
            state_q   <= READ;
            grant_b_q <= pick;
            addr_q    <= pick ? b_addr : a_addr;
            busy_q    <= 1'b1;
          end
        end
        READ: begin
          state_q <= ACK;
          if (grant_b_q) begin
            b_rdata_q <= rom_data;
            b_ack_q   <= 1'b1;
          end else begin
            a_rdata_q <= rom_data;
            a_ack_q   <= 1'b1;
          end
        end
        ACK: begin
          state_q      <= IDLE;
          a_ack_q      <= 1'b0;
          b_ack_q      <= 1'b0;
          busy_q       <= 1'b0;
          last_grant_q <= grant_b_q;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // The ROM strobe and address come straight from registers, never from req.
  assign rom_oe   = (state_q == READ);
  assign rom_addr = addr_q;

  assign a_ack    = a_ack_q;
  assign b_ack    = b_ack_q;
  assign a_rdata  = a_rdata_q;
  assign b_rdata  = b_rdata_q;
  assign busy     = busy_q;
  assign grant_b  = grant_b_q;

endmodule : rom_arbiter

// File: tb/tb_rom_arbiter.sv
// Directed self-checking bench for rom_arbiter with a small ROM model.
// Expectations follow ROM_ARB_FIXED_PRIO_EN when the bench is built with it.
module tb_rom_arbiter;

  logic        clk;
  logic        reset;
  logic        a_req;
  logic [14:0] a_addr;
  logic        a_ack;
  logic [7:0]  a_rdata;
  logic        b_req;
  logic [14:0] b_addr;
  logic        b_ack;
  logic [7:0]  b_rdata;
  logic        rom_oe;
  logic [14:0] rom_addr;
  logic [7:0]  rom_data;
  logic        busy;
  logic        grant_b;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef ROM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  rom_arbiter #(.ADDR_WIDTH(15), .DATA_WIDTH(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .a_req    (a_req),
    .a_addr   (a_addr),
    .a_ack    (a_ack),
    .a_rdata  (a_rdata),
    .b_req    (b_req),
    .b_addr   (b_addr),
    .b_ack    (b_ack),
    .b_rdata  (b_rdata),
    .rom_oe   (rom_oe),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .busy     (busy),
    .grant_b  (grant_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] rom_byte(input logic [14:0] addr);
    case (addr)
      15'h1FFC: rom_byte = 8'h00;
      15'h0000: rom_byte = 8'hA9;
      15'h0001: rom_byte = 8'h42;
      15'h0055: rom_byte = 8'h55;
      15'h0100: rom_byte = 8'h11;
      15'h0200: rom_byte = 8'h22;
      15'h0300: rom_byte = 8'h33;
      15'h4000: rom_byte = 8'h77;
      15'h7FFF: rom_byte = 8'hEE;
      default:  rom_byte = 8'hFF;
    endcase
  endfunction

  // A junk value stands in for the floating bus so mistimed captures show up.
  assign rom_data = rom_oe ? rom_byte(rom_addr) : 8'hDE;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      check("one_ack", 32'(a_ack & b_ack), 32'd0);
      if (rom_oe) check("oe_only_in_read", 32'(busy & ~a_ack & ~b_ack), 32'd1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    #2 reset = 1'b0;
    step();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_a_ack"},    32'(a_ack),    32'd0);
    check({tag, "_b_ack"},    32'(b_ack),    32'd0);
    check({tag, "_rom_oe"},   32'(rom_oe),   32'd0);
    check({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
    check({tag, "_a_rdata"},  32'(a_rdata),  32'd0);
    check({tag, "_b_rdata"},  32'(b_rdata),  32'd0);
    check({tag, "_busy"},     32'(busy),     32'd0);
    check({tag, "_grant_b"},  32'(grant_b),  32'd0);
  endtask

  // Single uncontended read on one port; the other port's rdata must hold.
  task automatic read_one(input logic port_b, input logic [14:0] addr,
                          input logic [7:0] exp, input logic [7:0] other_exp);
    if (port_b) begin
      b_req = 1'b1; b_addr = addr;
    end else begin
      a_req = 1'b1; a_addr = addr;
    end
    step();
    check("rd_oe",    32'(rom_oe),        32'd1);
    check("rd_addr",  32'(rom_addr),      32'(addr));
    check("rd_grant", 32'(grant_b),       32'(port_b));
    check("rd_busy",  32'(busy),          32'd1);
    check("rd_noack", 32'(a_ack | b_ack), 32'd0);
    step();
    check("ack_oe",    32'(rom_oe), 32'd0);
    check("ack_a",     32'(a_ack),  32'(!port_b));
    check("ack_b",     32'(b_ack),  32'(port_b));
    check("ack_rdata", 32'(port_b ? b_rdata : a_rdata), 32'(exp));
    check("ack_other", 32'(port_b ? a_rdata : b_rdata), 32'(other_exp));
    a_req = 1'b0;
    b_req = 1'b0;
    step();
    check("idle_busy",  32'(busy),          32'd0);
    check("idle_noack", 32'(a_ack | b_ack), 32'd0);
    check("idle_other", 32'(port_b ? a_rdata : b_rdata), 32'(other_exp));
  endtask

  initial begin
    reset  = 1'b0;
    a_req  = 1'b0;
    b_req  = 1'b0;
    a_addr = '0;
    b_addr = '0;
    #1;
    do_reset();
    check_all_zero("rst");

    // Single A read of the reset vector.
    read_one(1'b0, 15'h1FFC, 8'h00, 8'h00);

    // Simultaneous first requests after reset: A wins, B follows 3 cycles later.
    do_reset();
    a_req = 1'b1; a_addr = 15'h0000;
    b_req = 1'b1; b_addr = 15'h0001;
    step();
    check("tie_rd_grant", 32'(grant_b),  32'd0);
    check("tie_rd_addr",  32'(rom_addr), 32'h0000);
    step();
    check("tie_a_ack",   32'(a_ack),   32'd1);
    check("tie_a_rdata", 32'(a_rdata), 32'hA9);
    check("tie_b_wait",  32'(b_ack),   32'd0);
    a_req = 1'b0;
    step();
    check("tie_idle", 32'(a_ack | b_ack), 32'd0);
    step();
    check("tie_b_grant", 32'(grant_b),  32'd1);
    check("tie_b_addr",  32'(rom_addr), 32'h0001);
    step();
    check("tie_b_ack",   32'(b_ack),   32'd1);
    check("tie_b_rdata", 32'(b_rdata), 32'h42);
    check("tie_a_hold",  32'(a_rdata), 32'hA9);
    b_req = 1'b0;
    step();

    // Continuous contention for 12 cycles.
    a_req = 1'b1; a_addr = 15'h0100;
    b_req = 1'b1; b_addr = 15'h0200;
    for (int k = 1; k <= 12; k++) begin
      step();
      check("cont_a_ack", 32'(a_ack), 32'((k % 3 == 2) && (FIXED || (k % 6 == 2))));
      check("cont_b_ack", 32'(b_ack), 32'(!FIXED && (k % 6 == 5)));
      if (a_ack) check("cont_a_rdata", 32'(a_rdata), 32'h11);
      if (b_ack) check("cont_b_rdata", 32'(b_rdata), 32'h22);
    end
    a_req = 1'b0;
    b_req = 1'b0;
    step();
    check("cont_idle", 32'(busy), 32'd0);

    // B reads 0x55, then A reads several times while b_rdata must hold.
    read_one(1'b1, 15'h0055, 8'h55, 8'h11);
    read_one(1'b0, 15'h0300, 8'h33, 8'h55);
    read_one(1'b0, 15'h7FFF, 8'hEE, 8'h55);
    read_one(1'b0, 15'h0000, 8'hA9, 8'h55);

    // Reset in the middle of a B read.
    b_req = 1'b1; b_addr = 15'h4000;
    step();
    check("mid_rd_oe",    32'(rom_oe),  32'd1);
    check("mid_rd_grant", 32'(grant_b), 32'd1);
    #2 reset = 1'b1;
    #1;
    check_all_zero("async_rst");
    step();
    check_all_zero("held_rst");
    b_req = 1'b0;
    #2 reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("post_rst_noack", 32'(a_ack | b_ack), 32'd0);
      check("post_rst_busy",  32'(busy),          32'd0);
    end
    a_req = 1'b1; a_addr = 15'h0001;
    b_req = 1'b1; b_addr = 15'h4000;
    step();
    check("rst_tie_grant", 32'(grant_b),  32'd0);
    check("rst_tie_addr",  32'(rom_addr), 32'h0001);
    step();
    check("rst_tie_a_ack",   32'(a_ack),   32'd1);
    check("rst_tie_a_rdata", 32'(a_rdata), 32'h42);
    a_req = 1'b0;
    step();
    step();
    check("rst_tie_b_grant", 32'(grant_b),  32'd1);
    check("rst_tie_b_addr",  32'(rom_addr), 32'h4000);
    step();
    check("rst_tie_b_ack",   32'(b_ack),   32'd1);
    check("rst_tie_b_rdata", 32'(b_rdata), 32'h77);
    b_req = 1'b0;
    step();

    // Late deassert: A's req still high in the following IDLE starts a second access.
    a_req = 1'b1; a_addr = 15'h0300;
    step();
    check("late_rd1_oe", 32'(rom_oe), 32'd1);
    step();
    check("late_ack1",   32'(a_ack),   32'd1);
    check("late_rdata1", 32'(a_rdata), 32'h33);
    step();
    check("late_idle_ack", 32'(a_ack),  32'd0);
    check("late_idle_oe",  32'(rom_oe), 32'd0);
    step();
    check("late_rd2_oe",   32'(rom_oe),   32'd1);
    check("late_rd2_addr", 32'(rom_addr), 32'h0300);
    a_req = 1'b0;
    step();
    check("late_ack2",   32'(a_ack),   32'd1);
    check("late_rdata2", 32'(a_rdata), 32'h33);
    step();
    check("late_done_ack", 32'(a_ack), 32'd0);
    step();
    check("late_no_third", 32'(rom_oe | busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_rom_arbiter

// File: doc/rom_arbiter.md
# rom_arbiter

Two-port arbiter that shares the single 8-bit program ROM between the 6502 fetch path (port A) and a secondary reader such as the DMA/boot copier (port B). It serialises requests, drives the ROM's address and output-enable for exactly one read cycle per grant, registers the returned byte, and hands it back with a one-cycle acknowledge. It sits between the requesters and the ROM, and is the only driver of the ROM's `output_enable`.

## Interface
Parameters:
- `ADDR_WIDTH`, 15: address width passed to the ROM.
- `DATA_WIDTH`, 8: ROM data width.

Ports:
- `clk` in 1: single system clock, rising-edge.
- `reset` in 1: asynchronous, active-high reset.
- `a_req` in 1: port A read request, level; held until `a_ack`.
- `a_addr` in ADDR_WIDTH: port A address, stable while `a_req` is high.
- `a_ack` out 1: one-cycle pulse; `a_rdata` valid in the same cycle.
- `a_rdata` out DATA_WIDTH: last byte read for port A; held until the next `a_ack`.
- `b_req`, `b_addr`, `b_ack`, `b_rdata`: same as port A, for port B.
- `rom_oe` out 1: ROM output enable.
- `rom_addr` out ADDR_WIDTH: ROM address.
- `rom_data` in DATA_WIDTH: ROM read data. Combinational from `rom_addr`; high-Z when `rom_oe` is low.
- `busy` out 1: high in READ and ACK.
- `grant_b` out 1: port granted for the current or most recent access (0 = A, 1 = B).

## Operation
- FSM states: IDLE, READ, ACK.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one request: grant that port and go to READ.
  - Both requesting: round-robin. Grant the port not granted last (`last_grant`), then go to READ.
- READ:
  - `rom_oe`=1 and `rom_addr` = granted port's address, registered on entry (`addr_q`).
  - At the end of the cycle, capture `rom_data` into the granted port's rdata register and go to ACK.
- ACK:
  - Granted port's ack = 1.
  - Update `last_grant`.
  - Go to IDLE.
- Requester obligation: deassert req on the clock edge that ends the ack cycle. A req still high in the following IDLE cycle is treated as a new request.
- `rom_oe`=0 in IDLE and ACK, so the ROM bus is tri-stated. `rom_addr` holds `addr_q` when `rom_oe` is low.
- Addresses pass through unmodified. The ROM does its own address masking.
- The non-granted port's req is ignored until the next IDLE. Its ack stays 0 and its rdata is unchanged.
- Asynchronous reset clears all state, including in the middle of READ or ACK:
  - state = IDLE, `a_ack`=`b_ack`=0, `rom_oe`=0.
  - `rom_addr`=0, `a_rdata`=`b_rdata`=0.
  - `busy`=0, `grant_b`=0, `last_grant`=B, so A wins the first tie.
  - An access in flight is dropped with no ack. Its requester must re-request.

## Timing
- Latency: req seen high in IDLE at cycle n → READ in n+1 → ack and rdata in n+2.
- Throughput: one access per 3 cycles. Alternating A/B under continuous contention gives ack cadence A, B, A, B… at a 3-cycle spacing.
- `rdata` is registered and changes only at the edge that enters ACK for that port.
- All outputs are registered except `rom_addr`/`rom_oe`, which decode directly from state and `addr_q` (no combinational path from req).
- At most one ack is high in any cycle.

## Configuration
- `ROM_ARB_FIXED_PRIO_EN`:
  - Defined: port A always wins a tie, `last_grant` is unused and does not affect arbitration, and port B can starve.
  - Undefined (default): round-robin as above.
  - `grant_b` reports the granted port in both modes.

## Structure
- Package `rom_arb_pkg`:
  - typedef for the state enum: IDLE, READ, ACK.
  - Port-id constants: PORT_A=0, PORT_B=1.
  - Default `ADDR_WIDTH`/`DATA_WIDTH` constants.
- Sub-module `rr_pick2`: combinational 2-way picker with inputs `req[1:0]` and `last_grant`, output `grant`. It holds the `ROM_ARB_FIXED_PRIO_EN` selection so the top-level FSM is mode-independent.

## Test plan
- Single A read: ROM model with 0x1FFC=0x00; A requests 0x1FFC → `rom_oe` high exactly one cycle, `a_ack` at n+2, `a_rdata`=0x00, `b_ack` never asserts.
- Simultaneous first requests: A=0x0000 (data 0xA9), B=0x0001 (data 0x42) → A acked first with 0xA9, B acked 3 cycles later with 0x42.
- Continuous contention for 12 cycles → acks alternate A, B, A, B. With `ROM_ARB_FIXED_PRIO_EN` defined → only A acks while A's req is held continuously.
- Hold check: B reads 0x55, then A completes several reads → `b_rdata` stays 0x55 throughout; `rom_oe` is never high outside READ.
- Reset asserted during READ → next cycle outputs are all 0, state is IDLE, and no ack is issued. After release, a tie is granted to A.
- Late deassert: A holds req one cycle past ack → a second A access starts (`rom_oe` pulses again) and a second `a_ack` follows 2 cycles later.
